// File: rtl/host_wg_intake_queue.sv
// Host intake stage of the workgroup dispatcher.
// Captures descriptors from the host valid/ack handshake, checks that the
// per-wavefront resource sizes match the totals, and queues good descriptors
// in a first-word fall-through FIFO for the inflight WG buffer. Malformed
// descriptors are acknowledged, dropped and counted.
module host_wg_intake_queue #(
    parameter int WG_ID_WIDTH      = 6,
    parameter int WF_COUNT_WIDTH   = 4,
    parameter int WAVE_ITEM_WIDTH  = 6,
    parameter int MEM_ADDR_WIDTH   = 32,
    parameter int VGPR_ID_WIDTH    = 8,
    parameter int SGPR_ID_WIDTH    = 4,
    parameter int LDS_ID_WIDTH     = 8,
    parameter int GDS_ID_WIDTH     = 14,
    parameter int QUEUE_DEPTH_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        host_wg_valid,
    input  logic [WG_ID_WIDTH-1:0]      host_wg_id,
    input  logic [WF_COUNT_WIDTH-1:0]   host_num_wf,
    input  logic [WAVE_ITEM_WIDTH-1:0]  host_wf_size,
    input  logic [VGPR_ID_WIDTH:0]      host_vgpr_size_per_wf,
    input  logic [VGPR_ID_WIDTH:0]      host_vgpr_size_total,
    input  logic [SGPR_ID_WIDTH:0]      host_sgpr_size_per_wf,
    input  logic [SGPR_ID_WIDTH:0]      host_sgpr_size_total,
    input  logic [LDS_ID_WIDTH:0]       host_lds_size_total,
    input  logic [GDS_ID_WIDTH:0]       host_gds_size_total,
    input  logic [MEM_ADDR_WIDTH-1:0]   host_start_pc,
    output logic                        inflight_wg_buffer_host_rcvd_ack,

    output logic                        intake_wg_valid,
    input  logic                        intake_wg_ready,
    output logic [WG_ID_WIDTH-1:0]      intake_wg_id,
    output logic [WF_COUNT_WIDTH-1:0]   intake_num_wf,
    output logic [WAVE_ITEM_WIDTH-1:0]  intake_wf_size,
    output logic [VGPR_ID_WIDTH:0]      intake_vgpr_size_per_wf,
    output logic [VGPR_ID_WIDTH:0]      intake_vgpr_size_total,
    output logic [SGPR_ID_WIDTH:0]      intake_sgpr_size_per_wf,
    output logic [SGPR_ID_WIDTH:0]      intake_sgpr_size_total,
    output logic [LDS_ID_WIDTH:0]       intake_lds_size_total,
    output logic [GDS_ID_WIDTH:0]       intake_gds_size_total,
    output logic [MEM_ADDR_WIDTH-1:0]   intake_start_pc,
    output logic [QUEUE_DEPTH_LOG2:0]   intake_queue_count,
    output logic [7:0]                  intake_err_count
);

    localparam int DEPTH  = 1 << QUEUE_DEPTH_LOG2;
    localparam int VGPR_W = VGPR_ID_WIDTH + 1;
    localparam int SGPR_W = SGPR_ID_WIDTH + 1;
    localparam int VPROD_W = VGPR_W + WF_COUNT_WIDTH;
    localparam int SPROD_W = SGPR_W + WF_COUNT_WIDTH;

    localparam logic [QUEUE_DEPTH_LOG2:0]   CNT_FULL = (QUEUE_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [QUEUE_DEPTH_LOG2:0]   CNT_ONE  = (QUEUE_DEPTH_LOG2+1)'(1);
    localparam logic [QUEUE_DEPTH_LOG2-1:0] PTR_ONE  = (QUEUE_DEPTH_LOG2)'(1);

    typedef struct packed {
        logic [WG_ID_WIDTH-1:0]     wg_id;
        logic [WF_COUNT_WIDTH-1:0]  num_wf;
        logic [WAVE_ITEM_WIDTH-1:0] wf_size;
        logic [VGPR_W-1:0]          vgpr_per_wf;
        logic [VGPR_W-1:0]          vgpr_total;
        logic [SGPR_W-1:0]          sgpr_per_wf;
        logic [SGPR_W-1:0]          sgpr_total;
        logic [LDS_ID_WIDTH:0]      lds_total;
        logic [GDS_ID_WIDTH:0]      gds_total;
        logic [MEM_ADDR_WIDTH-1:0]  start_pc;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DROP
    } state_t;

    state_t                      state_q;
    desc_t                       stage_q;
    logic                        ack_q;
    desc_t                       mem_q [DEPTH];
    logic [QUEUE_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [QUEUE_DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]                  err_q;

    desc_t                       host_desc;
    desc_t                       head_out;
    logic [VPROD_W-1:0]          vgpr_prod;
    logic [SPROD_W-1:0]          sgpr_prod;
    logic                        desc_ok;
    logic                        fifo_full;
    logic                        push;
    logic                        pop;

    // Gather the host descriptor ports into one record for capture.
    always_comb begin
        host_desc             = '0;
        host_desc.wg_id       = host_wg_id;
        host_desc.num_wf      = host_num_wf;
        host_desc.wf_size     = host_wf_size;
        host_desc.vgpr_per_wf = host_vgpr_size_per_wf;
        host_desc.vgpr_total  = host_vgpr_size_total;
        host_desc.sgpr_per_wf = host_sgpr_size_per_wf;
        host_desc.sgpr_total  = host_sgpr_size_total;
        host_desc.lds_total   = host_lds_size_total;
        host_desc.gds_total   = host_gds_size_total;
        host_desc.start_pc    = host_start_pc;
    end

    // Sanity check of the staged descriptor; products are kept at full width
    // so a product that overflows the total field can never alias a match.
    always_comb begin
        vgpr_prod = {{WF_COUNT_WIDTH{1'b0}}, stage_q.vgpr_per_wf}
                  * {{VGPR_W{1'b0}}, stage_q.num_wf};
        sgpr_prod = {{WF_COUNT_WIDTH{1'b0}}, stage_q.sgpr_per_wf}
                  * {{SGPR_W{1'b0}}, stage_q.num_wf};
        desc_ok   = (stage_q.num_wf != '0)
                  && (stage_q.wf_size != '0)
                  && (vgpr_prod == {{WF_COUNT_WIDTH{1'b0}}, stage_q.vgpr_total})
                  && (sgpr_prod == {{WF_COUNT_WIDTH{1'b0}}, stage_q.sgpr_total});
    end

    assign fifo_full       = (count_q == CNT_FULL);
    assign intake_wg_valid = (count_q != '0);
    assign push            = (state_q == ST_CHECK) && desc_ok;
    assign pop             = intake_wg_valid && intake_wg_ready;

    // Host handshake FSM: capture, check for one cycle, then wait for the
    // host to release valid so a held descriptor is never taken twice.
    always_ff @(posedge clk) begin
        // NOTE: every register update uses <= so all flops sample the same
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (host_wg_valid && !fifo_full) begin
                        stage_q <= host_desc;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    ack_q   <= 1'b1;
                    state_q <= ST_DROP;
                end
                ST_DROP: begin
                    if (!host_wg_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only ever
        // observed through count_q, which is reset, and the head outputs are
        // forced to zero while the FIFO is empty.
        if (push) begin
            mem_q[wr_ptr_q] <= stage_q;
        end
    end

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Saturating count of descriptors dropped by the check.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if ((state_q == ST_CHECK) && !desc_ok && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    // Head of queue, held at zero while empty.
    always_comb begin
        head_out = '0;
        if (intake_wg_valid) begin
            head_out = mem_q[rd_ptr_q];
        end
    end

    assign inflight_wg_buffer_host_rcvd_ack = ack_q;
    assign intake_wg_id            = head_out.wg_id;
    assign intake_num_wf           = head_out.num_wf;
    assign intake_wf_size          = head_out.wf_size;
    assign intake_vgpr_size_per_wf = head_out.vgpr_per_wf;
    assign intake_vgpr_size_total  = head_out.vgpr_total;
    assign intake_sgpr_size_per_wf = head_out.sgpr_per_wf;
    assign intake_sgpr_size_total  = head_out.sgpr_total;
    assign intake_lds_size_total   = head_out.lds_total;
    assign intake_gds_size_total   = head_out.gds_total;
    assign intake_start_pc         = head_out.start_pc;
    assign intake_queue_count      = count_q;
    assign intake_err_count        = err_q;

endmodule
